// File: rtl/serial_rx_pkg.sv
// Shared definitions for the serial link: receiver state encoding and default bit timing.
package serial_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    // 50 MHz clock, 115200 baud
    localparam int DEFAULT_CLK_PER_BIT = 434;

endpackage

// File: rtl/serial_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; reset value chosen by the instantiator.
module serial_rx_sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/serial_rx.sv
// 8N1 UART receiver, LSB first: start-edge detect, mid-bit sampling, one-cycle
// new_data / frame_err strobes.
module serial_rx
    import serial_rx_pkg::*;
#(
    parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       new_data,
    output logic       busy,
    output logic       frame_err
);

    localparam int CTR_SIZE = $clog2(CLK_PER_BIT);
    localparam logic [CTR_SIZE-1:0] HALF_LAST = CTR_SIZE'(CLK_PER_BIT / 2 - 1);
    localparam logic [CTR_SIZE-1:0] BIT_LAST  = CTR_SIZE'(CLK_PER_BIT - 1);

    logic rx_s;

    // Reset to the idle level so leaving reset never looks like a start edge.
    serial_rx_sync_2ff #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (rx),
        .q    (rx_s)
    );

    rx_state_e           state_q,     state_d;
    logic [CTR_SIZE-1:0] ctr_q,       ctr_d;
    logic [2:0]          idx_q,       idx_d;
    logic [7:0]          sr_q,        sr_d;
    logic [7:0]          data_q,      data_d;
    logic                new_data_q,  new_data_d;
    logic                frame_err_q, frame_err_d;
    logic                rx_prev_q;

    always_comb begin
        state_d     = state_q;
        ctr_d       = ctr_q;
        idx_d       = idx_q;
        sr_d        = sr_q;
        data_d      = data_q;
        new_data_d  = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                ctr_d = '0;
                if (rx_prev_q && !rx_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (ctr_q == HALF_LAST) begin
                    ctr_d = '0;
                    idx_d = 3'd0;
                    // A line already back high at mid start bit was a glitch.
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    ctr_d = ctr_q + CTR_SIZE'(1);
                end
            end
            ST_DATA: begin
                if (ctr_q == BIT_LAST) begin
                    ctr_d       = '0;
                    sr_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    ctr_d = ctr_q + CTR_SIZE'(1);
                end
            end
            ST_STOP: begin
                if (ctr_q == BIT_LAST) begin
                    ctr_d   = '0;
                    state_d = ST_IDLE;
                    if (rx_s) begin
                        data_d     = sr_q;
                        new_data_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    ctr_d = ctr_q + CTR_SIZE'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                ctr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ctr_q       <= '0;
            idx_q       <= 3'd0;
            sr_q        <= 8'h00;
            data_q      <= 8'h00;
            new_data_q  <= 1'b0;
            frame_err_q <= 1'b0;
            rx_prev_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            idx_q       <= idx_d;
            sr_q        <= sr_d;
            data_q      <= data_d;
            new_data_q  <= new_data_d;
            frame_err_q <= frame_err_d;
            rx_prev_q   <= rx_s;
        end
    end

    assign data      = data_q;
    assign new_data  = new_data_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// Randomized and directed 8N1 stimulus against serial_rx; a queue-based scoreboard
// checks every strobe's kind, byte and arrival cycle.
`timescale 1ns/1ps
module tb_serial_rx;

    localparam int CPB = 434;
    // Strobe lands mid stop bit: 2 sync + 1 edge detect + half bit + 9 full bits.
    localparam int LAT = 3 + CPB / 2 + 9 * CPB;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       new_data;
    logic       busy;
    logic       frame_err;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc_cnt = 0;
    exp_t       exp_q[$];
    logic [7:0] last_good = 8'h00;

    serial_rx #(.CLK_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .data     (data),
        .new_data (new_data),
        .busy     (busy),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc_cnt);
        end
    endtask

    // Caller must be at a negedge. Sends start, 8 data bits LSB first, stop; a low stop
    // bit is followed by hold_bits of extra low and then one bit of idle high.
    task automatic send_frame(input logic [7:0] b, input int per, input bit stop_ok,
                              input int hold_bits, input bit expect_out);
        exp_t e;
        if (expect_out) begin
            e.is_err = !stop_ok;
            e.data   = stop_ok ? b : last_good;
            e.cyc    = cyc_cnt + LAT;
            exp_q.push_back(e);
            if (stop_ok) last_good = b;
        end
        rx = 1'b0;
        repeat (per) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (per) @(negedge clk);
        end
        rx = stop_ok;
        repeat (per) @(negedge clk);
        if (!stop_ok) begin
            repeat (hold_bits * per) @(negedge clk);
            rx = 1'b1;
            repeat (per) @(negedge clk);
        end
    endtask

    // Scoreboard monitor: every strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && (new_data || frame_err)) begin
            check("strobe_exclusive", {31'd0, new_data & frame_err}, 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_strobe: new_data=%0b frame_err=%0b data=%0h cycle %0d",
                         new_data, frame_err, data, cyc_cnt);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("strobe_kind_err", {31'd0, frame_err}, {31'd0, e.is_err});
                check("strobe_data", {24'd0, data}, {24'd0, e.data});
                check("strobe_cycle", cyc_cnt, e.cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_data", {24'd0, data}, 32'h00);
        check("rst_new_data", {31'd0, new_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Single byte with busy timing around the start edge.
        fork
            send_frame(8'h61, CPB, 1'b1, 0, 1'b1);
            begin
                @(negedge clk);
                check("busy_before_sync", {31'd0, busy}, 32'd0);
                repeat (4) @(negedge clk);
                check("busy_in_frame", {31'd0, busy}, 32'd1);
            end
        join
        check("data_61", {24'd0, data}, 32'h61);
        check("busy_after_61", {31'd0, busy}, 32'd0);
        repeat (20) @(negedge clk);

        // Back-to-back frames, no idle gap.
        send_frame(8'h00, CPB, 1'b1, 0, 1'b1);
        send_frame(8'hFF, CPB, 1'b1, 0, 1'b1);
        check("data_ff", {24'd0, data}, 32'hFF);
        repeat (50) @(negedge clk);

        // Short low glitch on an idle line.
        rx = 1'b0;
        repeat (100) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
        check("glitch_busy", {31'd0, busy}, 32'd0);
        check("glitch_data", {24'd0, data}, {24'd0, last_good});

        // Framing error followed by a 20-bit break.
        send_frame(8'hA5, CPB, 1'b0, 20, 1'b1);
        check("break_busy", {31'd0, busy}, 32'd0);
        check("break_data", {24'd0, data}, {24'd0, last_good});
        repeat (50) @(negedge clk);

        // Reset during bit 4 of 8'h3C, held until that frame is over.
        fork
            send_frame(8'h3C, CPB, 1'b1, 0, 1'b0);
            begin
                repeat (5 * CPB + CPB / 2) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                check("midrst_data", {24'd0, data}, 32'h00);
                check("midrst_new_data", {31'd0, new_data}, 32'd0);
                check("midrst_busy", {31'd0, busy}, 32'd0);
                check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
            end
        join
        last_good = 8'h00;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'hC3, CPB, 1'b1, 0, 1'b1);
        check("data_c3", {24'd0, data}, 32'hC3);
        repeat (20) @(negedge clk);

        // Transmitter bit period 3% slow, then 3% fast.
        send_frame(8'h55, 447, 1'b1, 0, 1'b1);
        check("data_55_slow", {24'd0, data}, 32'h55);
        repeat (20) @(negedge clk);
        send_frame(8'h55, 421, 1'b1, 0, 1'b1);
        check("data_55_fast", {24'd0, data}, 32'h55);

        // Random bytes, rates within tolerance, occasional bad stop, random gaps.
        for (int k = 0; k < 4; k++) begin
            logic [7:0] b;
            int         per;
            bit         ok;
            b   = 8'($urandom);
            per = 421 + int'($urandom_range(0, 26));
            ok  = ($urandom_range(0, 3) != 0);
            send_frame(b, per, ok, 0, 1'b1);
            check("rand_data_held", {24'd0, data}, {24'd0, last_good});
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 50)) @(negedge clk);
        end

        repeat (CPB) @(negedge clk);
        check("pending_strobes", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
